// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cdb_arbiter_pkg
//  Brief   : Shared widths and helpers for the common-data-bus arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

   localparam int NUM_SRBITS  = 8;
   localparam int CDB_DATA_W  = 32;
   localparam int CDB_NUM_REQ = 4;
   localparam int NUM_CDBBITS = 1 + NUM_SRBITS + CDB_DATA_W;
   localparam int CNT_W       = 16;

   // Round-robin successor that also works when n is not a power of two.
   function automatic int rr_next(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter
//  Brief   : Combinational round-robin arbiter, search starts at ptr.
//  Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter  int N     = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [2*N-1:0] dbl_req;
   logic [2*N-1:0] masked;
   logic           found;
   int             first_pos;

   // The upper copy of req covers the wrap-around, so the lowest set bit of
   // the masked vector is the first requester at or after ptr.
   always_comb begin
      dbl_req   = {req, req};
      masked    = dbl_req & ({(2*N){1'b1}} << ptr);
      found     = 1'b0;
      first_pos = 0;
      for (int j = 2*N-1; j >= 0; j--) begin
         if (masked[j]) begin
            found     = 1'b1;
            first_pos = j;
         end
      end
      gnt_idx = IDX_W'((first_pos >= N) ? first_pos - N : first_pos);
      gnt     = (en && found) ? (N'(1) << gnt_idx) : '0;
   end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : cdb_arbiter
//  Brief   : Round-robin arbitration of FU results onto the registered CDB.
//  Revision: 1.0 - initial release
// ============================================================================
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter  int N_REQ  = CDB_NUM_REQ,
   parameter  int TAG_W  = NUM_SRBITS,
   parameter  int DATA_W = CDB_DATA_W,
   localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CDB_W  = 1 + TAG_W + DATA_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*TAG_W-1:0]  req_tag,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    flush,
   output logic [CDB_W-1:0]        cdb,
   output logic [IDX_W-1:0]        grant_id,
   output logic [CNT_W-1:0]        conflict_cnt,
   output logic                    bad_tag_err
);

   logic [N_REQ-1:0]  gnt;
   logic [IDX_W-1:0]  gnt_idx;
   logic              arb_en;
   logic              xfer;
   logic              multi_req;
   int                valid_cnt;
   logic [TAG_W-1:0]  win_tag;
   logic [DATA_W-1:0] win_data;

   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [CDB_W-1:0]  cdb_q, cdb_d;
   logic [IDX_W-1:0]  gid_q, gid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   // Ready is held low in reset and during flush so nothing drains then.
   assign arb_en = rst_n & ~flush;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req     (req_valid),
      .ptr     (ptr_q),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign xfer      = |gnt;
   assign win_tag   = req_tag[int'(gnt_idx)*TAG_W +: TAG_W];
   assign win_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

   always_comb begin
      valid_cnt = 0;
      for (int i = 0; i < N_REQ; i++) begin
         valid_cnt = valid_cnt + int'(req_valid[i]);
      end
      multi_req = (valid_cnt > 1);
   end

   always_comb begin
      ptr_d = ptr_q;
      cdb_d = '0;
      gid_d = gid_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (xfer) begin
         ptr_d = IDX_W'(rr_next(int'(gnt_idx), N_REQ));
         gid_d = gnt_idx;
         // Tag 0 is drained from the FU but never broadcast.
         if (win_tag == '0) begin
            err_d = 1'b1;
         end else begin
            cdb_d = {1'b1, win_tag, win_data};
         end
      end
      if (multi_req && !flush && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cdb_q <= '0;
         gid_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cdb_q <= cdb_d;
         gid_q <= gid_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign cdb          = cdb_q;
   assign grant_id     = gid_q;
   assign conflict_cnt = cnt_q;
   assign bad_tag_err  = err_q;

endmodule
`default_nettype wire
